sort_splitter: RTL and testbench
================================

SORT_SPLITTER -- requirements
Module: sort_splitter

Interface
REQ-001 Parameter DATA_WIDTH, default 12: width of every data word.
REQ-002 Parameter ACTIVE_MSB, default 11: MSB of the routing key field.
REQ-003 Parameter ACTIVE_LSB, default 6: LSB of the routing key field; key width KW = ACTIVE_MSB-ACTIVE_LSB+1.
REQ-004 Port clk, input, 1: clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1: reset, synchronous, active-high.
REQ-006 Port en, input, 1: enable; when low, no word is accepted.
REQ-007 Port split, input, KW: routing threshold.
REQ-008 Port in, input, DATA_WIDTH: upstream data word.
REQ-009 Port valid_i, input, 1: upstream word present.
REQ-010 Port outread, output, 1: combinational pull; word on in is consumed this cycle.
REQ-011 Port outA, output, DATA_WIDTH: head word of stream A.
REQ-012 Port voutA, output, 1: outA valid.
REQ-013 Port inReadA, input, 1: downstream A consumes outA this cycle when voutA=1.
REQ-014 Port outB, output, DATA_WIDTH: head word of stream B.
REQ-015 Port voutB, output, 1: outB valid.
REQ-016 Port inReadB, input, 1: downstream B consumes outB this cycle when voutB=1.
REQ-017 Port cntA, output, 8: words routed to A since reset.
REQ-018 Port cntB, output, 8: words routed to B since reset.

Function
REQ-019 Routing: key = in[ACTIVE_MSB:ACTIVE_LSB]; key < split (unsigned) selects A; key >= split selects B.
REQ-020 Each output has a 2-entry FIFO; occupancy occA, occB in {0,1,2}; outX/voutX are the FIFO head, registered.
REQ-021 popX = voutX && inReadX; inReadX with voutX=0 has no effect.
REQ-022 Target not full when occX<2, or occX==2 and popX (same-cycle pop frees a slot).
REQ-023 outread = valid_i && en && (target for the current key not full); combinational from in, split, occupancy, inReadA/B.
REQ-024 On outread, word is written into the target FIFO at the next edge; it is visible at the head one cycle after acceptance when that FIFO is empty.
REQ-025 Simultaneous push and pop on the same FIFO: occupancy unchanged, head advances, order preserved.
REQ-026 Per-output order equals input arrival order; no word is duplicated or dropped.
REQ-027 Blocking: a full target stalls input (outread=0) even if the other FIFO has space; no reordering across streams.
REQ-028 When a FIFO becomes empty, voutX=0 and outX = all ones on the following cycle.
REQ-029 cntX increments by 1 on each word accepted into X, wraps 255 -> 0.
REQ-030 split and en are sampled combinationally each cycle; a change takes effect on the next acceptance only, never on stored words.
REQ-031 en=0 does not block draining: pops continue while en=0.

Reset
REQ-032 While reset=1: occA=occB=0, voutA=voutB=0, outA=outB=all ones, cntA=cntB=0, outread=0.
REQ-033 Reset mid-operation discards all buffered words; first acceptance is allowed on the cycle after reset deasserts.

Verification
REQ-034 split=0x20, inReadA=inReadB=1, words 0x0C5 (key 3) then 0x840 (key 33) -> outA=0x0C5 voutA=1, then outB=0x840 voutB=1; cntA=1, cntB=1.
REQ-035 split=0x20, inReadA=0, three key-3 words 0x0C1,0x0C2,0x0C3 -> first two accepted, outread=0 on third; assert inReadA -> 0x0C1,0x0C2,0x0C3 emitted in order.
REQ-036 occA=2, inReadA=1 same cycle as key-3 word valid -> outread=1, occA stays 2, no loss.
REQ-037 A full and stalled, B empty, next word key 40 -> outread=0 until A has space (no bypass).
REQ-038 256 words to B -> cntB wraps to 0, voutB/outB data unaffected.
REQ-039 Reset with occA=2, occB=1 -> next cycle voutA=voutB=0, outA=outB=0xFFF, counters 0.

Source files
------------

// File: rtl/sort_splitter.sv
// Routes each upstream word by its key field into one of two 2-entry output FIFOs.
// The input stalls whenever the FIFO for the presented word is full; the other stream is never bypassed.

module sort_splitter_fifo #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         inRead,
  output logic [W-1:0] dout,
  output logic         vout,
  output logic         blocked
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t         occ;
  logic [W-1:0] tail;
  logic         pop;

  assign pop = vout && inRead;
  // A same-cycle pop frees the slot the incoming word needs.
  assign blocked = (occ == FULL) && !pop;

  // The head register drives the outputs directly; an empty FIFO shows all ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ  <= EMPTY;
      vout <= 1'b0;
      dout <= '1;
    end else begin
      unique case (occ)
        EMPTY: begin
          if (push) begin
            dout <= din;
            vout <= 1'b1;
            occ  <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            dout <= din;
          end else if (push) begin
            occ <= FULL;
          end else if (pop) begin
            dout <= '1;
            vout <= 1'b0;
            occ  <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            dout <= tail;
            if (!push) occ <= ONE;
          end
        end
        default: occ <= EMPTY;
      endcase
    end
  end

  // NOTE: the second slot is pure storage gated by occupancy, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push && (((occ == ONE) && !pop) || ((occ == FULL) && pop))) begin
      tail <= din;
    end
  end

endmodule

module sort_splitter #(
  parameter int DATA_WIDTH = 12,
  parameter int ACTIVE_MSB = 11,
  parameter int ACTIVE_LSB = 6,
  localparam int KW = ACTIVE_MSB - ACTIVE_LSB + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [KW-1:0]         split,
  input  logic [DATA_WIDTH-1:0] in,
  input  logic                  valid_i,
  output logic                  outread,
  output logic [DATA_WIDTH-1:0] outA,
  output logic                  voutA,
  input  logic                  inReadA,
  output logic [DATA_WIDTH-1:0] outB,
  output logic                  voutB,
  input  logic                  inReadB,
  output logic [7:0]            cntA,
  output logic [7:0]            cntB
);

  logic [KW-1:0] key;
  logic          toA;
  logic          blockedA;
  logic          blockedB;
  logic          pushA;
  logic          pushB;

  assign key = in[ACTIVE_MSB:ACTIVE_LSB];
  assign toA = key < split;

  // NOTE: outread is combinational, so it is gated by reset explicitly rather than by a register.
  assign outread = !reset && valid_i && en && (toA ? !blockedA : !blockedB);
  assign pushA   = outread && toA;
  assign pushB   = outread && !toA;

  sort_splitter_fifo #(.W(DATA_WIDTH)) fifoA (
    .clk     (clk),
    .reset   (reset),
    .push    (pushA),
    .din     (in),
    .inRead  (inReadA),
    .dout    (outA),
    .vout    (voutA),
    .blocked (blockedA)
  );

  sort_splitter_fifo #(.W(DATA_WIDTH)) fifoB (
    .clk     (clk),
    .reset   (reset),
    .push    (pushB),
    .din     (in),
    .inRead  (inReadB),
    .dout    (outB),
    .vout    (voutB),
    .blocked (blockedB)
  );

  // Acceptance counters wrap naturally at 8 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      cntA <= '0;
      cntB <= '0;
    end else begin
      if (pushA) cntA <= cntA + 8'd1;
      if (pushB) cntB <= cntB + 8'd1;
    end
  end

endmodule

// File: tb/tb_sort_splitter.sv
// Scoreboard bench for sort_splitter: a driver predicts acceptance and queues expected words,
// a monitor compares each stream head and the counters every cycle.

module tb_sort_splitter;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [5:0]  split;
  logic [11:0] in;
  logic        valid_i;
  logic        outread;
  logic [11:0] outA;
  logic        voutA;
  logic        inReadA;
  logic [11:0] outB;
  logic        voutB;
  logic        inReadB;
  logic [7:0]  cntA;
  logic [7:0]  cntB;

  int checks = 0;
  int errors = 0;

  logic [11:0] qA[$];
  logic [11:0] qB[$];
  logic [7:0]  mCntA = 8'd0;
  logic [7:0]  mCntB = 8'd0;
  bit          monOn = 1'b0;

  always #5 clk = ~clk;

  sort_splitter dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .split   (split),
    .in      (in),
    .valid_i (valid_i),
    .outread (outread),
    .outA    (outA),
    .voutA   (voutA),
    .inReadA (inReadA),
    .outB    (outB),
    .voutB   (voutB),
    .inReadB (inReadB),
    .cntA    (cntA),
    .cntB    (cntB)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: runs 2 time units after each falling edge, before the driver's prediction.
  initial begin
    logic [11:0] tmp;
    forever begin
      @(negedge clk);
      #2;
      if (monOn) begin
        check("voutA", voutA, qA.size() > 0);
        if (qA.size() > 0) begin
          check("outA", outA, qA[0]);
          if (inReadA) tmp = qA.pop_front();
        end else begin
          check("outA_empty", outA, 12'hFFF);
        end
        check("voutB", voutB, qB.size() > 0);
        if (qB.size() > 0) begin
          check("outB", outB, qB[0]);
          if (inReadB) tmp = qB.pop_front();
        end else begin
          check("outB_empty", outB, 12'hFFF);
        end
        check("cntA", cntA, mCntA);
        check("cntB", cntB, mCntB);
      end
    end
  end

  // One clock of stimulus; acceptance is predicted from queue depth after this cycle's pops.
  task automatic step(input bit rst, input bit v, input bit e, input logic [5:0] sp,
                      input logic [11:0] w, input bit ra, input bit rb, output bit acc);
    bit toA;
    bit expAcc;
    @(negedge clk);
    reset   = rst;
    valid_i = v;
    en      = e;
    split   = sp;
    in      = w;
    inReadA = ra;
    inReadB = rb;
    #3;
    toA    = w[11:6] < sp;
    expAcc = !rst && v && e && (toA ? (qA.size() < 2) : (qB.size() < 2));
    check("outread", outread, expAcc);
    if (rst) begin
      qA.delete();
      qB.delete();
      mCntA = 8'd0;
      mCntB = 8'd0;
      monOn = 1'b1;
    end else if (expAcc) begin
      if (toA) begin
        qA.push_back(w);
        mCntA = mCntA + 8'd1;
      end else begin
        qB.push_back(w);
        mCntB = mCntB + 8'd1;
      end
    end
    acc = expAcc;
  endtask

  task automatic idle(input int n, input bit ra, input bit rb);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 6'h20, 12'h000, ra, rb, acc);
  endtask

  initial begin
    bit          acc;
    bit          v;
    bit          e;
    bit          ra;
    bit          rb;
    bit          rst;
    logic [5:0]  sp;
    logic [11:0] srcWord;

    reset = 1'b1; en = 1'b0; split = 6'h20; in = '0; valid_i = 1'b0;
    inReadA = 1'b0; inReadB = 1'b0;
    step(1'b1, 1'b0, 1'b0, 6'h20, 12'h000, 1'b0, 1'b0, acc);
    step(1'b1, 1'b1, 1'b1, 6'h20, 12'h0C5, 1'b1, 1'b1, acc);

    // Basic routing: key 3 goes to A, key 33 goes to B.
    step(1'b0, 1'b1, 1'b1, 6'h20, 12'h0C5, 1'b1, 1'b1, acc);
    step(1'b0, 1'b1, 1'b1, 6'h20, 12'h840, 1'b1, 1'b1, acc);
    idle(3, 1'b1, 1'b1);

    // Fill A, stall the third word, then accept it on the same cycle as a pop.
    step(1'b0, 1'b1, 1'b1, 6'h20, 12'h0C1, 1'b0, 1'b1, acc);
    step(1'b0, 1'b1, 1'b1, 6'h20, 12'h0C2, 1'b0, 1'b1, acc);
    step(1'b0, 1'b1, 1'b1, 6'h20, 12'h0C3, 1'b0, 1'b1, acc);
    step(1'b0, 1'b1, 1'b1, 6'h20, 12'h0C3, 1'b0, 1'b1, acc);
    step(1'b0, 1'b1, 1'b1, 6'h20, 12'h0C3, 1'b1, 1'b1, acc);
    idle(4, 1'b1, 1'b1);

    // A full and stalled: the following key-40 word waits behind the held A word.
    step(1'b0, 1'b1, 1'b1, 6'h20, 12'h0C4, 1'b0, 1'b0, acc);
    step(1'b0, 1'b1, 1'b1, 6'h20, 12'h0C5, 1'b0, 1'b0, acc);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 6'h20, 12'h0C6, 1'b0, 1'b0, acc);
    step(1'b0, 1'b1, 1'b1, 6'h20, 12'h0C6, 1'b1, 1'b0, acc);
    step(1'b0, 1'b1, 1'b1, 6'h20, 12'hA00, 1'b0, 1'b0, acc);
    idle(4, 1'b1, 1'b1);

    // Enable low blocks acceptance but not draining.
    step(1'b0, 1'b1, 1'b1, 6'h20, 12'h0C7, 1'b0, 1'b0, acc);
    step(1'b0, 1'b1, 1'b0, 6'h20, 12'h0C8, 1'b1, 1'b1, acc);
    idle(2, 1'b1, 1'b1);

    // Counter wrap on B after exactly 256 accepted words.
    step(1'b1, 1'b0, 1'b0, 6'h20, 12'h000, 1'b0, 1'b0, acc);
    for (int i = 0; i < 256; i++)
      step(1'b0, 1'b1, 1'b1, 6'h20, {6'd40, 6'(i)}, 1'b1, 1'b1, acc);
    idle(3, 1'b1, 1'b1);

    // Reset with buffered words in both FIFOs.
    step(1'b0, 1'b1, 1'b1, 6'h20, 12'h0D1, 1'b0, 1'b0, acc);
    step(1'b0, 1'b1, 1'b1, 6'h20, 12'h0D2, 1'b0, 1'b0, acc);
    step(1'b0, 1'b1, 1'b1, 6'h20, 12'hB01, 1'b0, 1'b0, acc);
    step(1'b1, 1'b1, 1'b1, 6'h20, 12'h0D3, 1'b0, 1'b0, acc);
    step(1'b0, 1'b1, 1'b1, 6'h20, 12'h0D3, 1'b1, 1'b1, acc);
    idle(3, 1'b1, 1'b1);

    // Randomized traffic: the source holds each word until it is accepted.
    sp      = 6'h20;
    srcWord = 12'($urandom);
    for (int i = 0; i < 4000; i++) begin
      v   = ($urandom % 10) < 7;
      e   = ($urandom % 8) != 0;
      ra  = ($urandom % 3) != 0;
      rb  = ($urandom % 2) != 0;
      rst = ($urandom % 300) == 0;
      if (($urandom % 25) == 0) sp = 6'($urandom_range(8, 56));
      step(rst, v, e, sp, srcWord, ra, rb, acc);
      if (acc) srcWord = 12'($urandom);
    end
    idle(6, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
